imm_decode_stage: RTL

//   Decode-side stage that sits directly upstream of the immediate extender.

---
 rtl/imm_decode_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/imm_decode_stage.sv
// Decode stage ahead of the immediate extender: opcode -> ExtOp/LUI/illegal,
// buffered in a 2-entry skid (main + skid register) with a registered in_ready.
module imm_decode_stage #(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_instr,
    input  logic [WIDTH-1:0]     in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_pc,
    output logic [IMM_WIDTH-1:0] out_imm16,
    output logic                 out_ext_op,
    output logic                 out_lui,
    output logic [4:0]           out_rs,
    output logic [4:0]           out_rt,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_shamt,
    output logic [25:0]          out_jtarget,
    output logic                 out_illegal
);

    typedef struct packed {
        logic [WIDTH-1:0]     pc;
        logic [IMM_WIDTH-1:0] imm16;
        logic                 ext_op;
        logic                 lui;
        logic [4:0]           rs;
        logic [4:0]           rt;
        logic [4:0]           rd;
        logic [4:0]           shamt;
        logic [25:0]          jtarget;
        logic                 illegal;
    } entry_t;

    function automatic entry_t decode(input logic [WIDTH-1:0] instr,
                                      input logic [WIDTH-1:0] pc);
        entry_t e;
        e         = '0;
        e.pc      = pc;
        e.imm16   = instr[IMM_WIDTH-1:0];
        e.rs      = instr[25:21];
        e.rt      = instr[20:16];
        e.rd      = instr[15:11];
        e.shamt   = instr[10:6];
        e.jtarget = instr[25:0];
        case (instr[31:26])
            6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h20, 6'h23, 6'h28, 6'h2B: e.ext_op = 1'b1;
            6'h0C, 6'h0D, 6'h0E:        e.ext_op = 1'b0;
            6'h0F:                      e.lui    = 1'b1;
            6'h00, 6'h02, 6'h03:        e.ext_op = 1'b0;
            default:                    e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    entry_t m_q, m_d, s_q, s_d;
    logic   m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept, m_free;
    entry_t dec;

    assign accept = in_valid && in_ready_q;
    assign m_free = !m_valid_q || out_ready;
    assign dec    = decode(in_instr, in_pc);

    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            // Anything accepted alongside a flush is on the wrong path.
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (m_free) begin
            if (s_valid_q) begin
                m_d       = s_q;
                m_valid_d = 1'b1;
                s_valid_d = accept;
                if (accept) s_d = dec;
            end else begin
                m_valid_d = accept;
                if (accept) m_d = dec;
            end
        end else if (accept) begin
            s_d       = dec;
            s_valid_d = 1'b1;
        end
        in_ready_d = !s_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q        <= '0;
            s_q        <= '0;
            m_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            m_q        <= m_d;
            s_q        <= s_d;
            m_valid_q  <= m_valid_d;
            s_valid_q  <= s_valid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = m_valid_q;
    assign out_pc      = m_q.pc;
    assign out_imm16   = m_q.imm16;
    assign out_ext_op  = m_q.ext_op;
    assign out_lui     = m_q.lui;
    assign out_rs      = m_q.rs;
    assign out_rt      = m_q.rt;
    assign out_rd      = m_q.rd;
    assign out_shamt   = m_q.shamt;
    assign out_jtarget = m_q.jtarget;
    assign out_illegal = m_q.illegal;

endmodule
